// File: rtl/phy_pkg.sv
// Shared helpers for the ping-pong channel capture block: width derivation and half indices.
package phy_pkg;

    localparam logic HALF0 = 1'b0;
    localparam logic HALF1 = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // Channel-index width; at least one bit so a 1-channel build still elaborates.
    function automatic int unsigned vw_of(input int unsigned nch);
        return (nch < 2) ? 1 : clog2(nch);
    endfunction

endpackage

// File: rtl/pp_frame_ram.sv
// Simple dual-port single-clock frame RAM with registered read; contents are not reset.
module pp_frame_ram import phy_pkg::*; #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2048
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic [clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]           rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    // Same-address read during write returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/phy_channel_pp.sv
// Per-channel slot capture into a ping-pong frame memory, published to a reader with
// ready/ack, a reader lock on the held half and a saturating frame-drop counter.
module phy_channel_pp import phy_pkg::*; #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 8,
    parameter int unsigned DCW = 8,
    localparam int unsigned VW = vw_of(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_sync,
    input  logic           i_slot_sync,
    input  logic [VW-1:0]  i_wr_vchn,
    input  logic [AW:0]    i_data_len,
    input  logic           i_in_vld,
    input  logic [DW-1:0]  i_in_data,
    input  logic           i_complite,
    input  logic           i_frame_ack,
    input  logic [VW-1:0]  i_rd_vchn,
    input  logic [AW-1:0]  i_rd_addr,
    output logic [DW-1:0]  o_rd_data,
    output logic [AW:0]    o_data_count,
    output logic [15:0]    o_out_size,
    output logic           o_frame_ready,
    output logic [DCW-1:0] o_drop_cnt
);

    localparam int unsigned DEPTH = 2 * NCH * (1 << AW);
    localparam int unsigned RAW   = clog2(DEPTH);

    logic           wr_half, rd_half, wr_active, rd_clr;
    logic [AW-1:0]  addr;
    logic [VW-1:0]  slot_vchn;
    logic [AW:0]    slot_len;
    logic [AW:0]    cnt  [2*NCH];
    logic [AW:0]    snap [NCH];
    logic [DW-1:0]  ram_rdata;

    logic           frame_free, publish, ready_d, rd_half_d, nxt_half;
    logic           wr_en, slot_end;
    logic [AW:0]    addr_inc;
    logic [15:0]    cnt_sum;

    assign frame_free = !o_frame_ready || i_frame_ack;
    assign publish    = i_complite && frame_free;
    assign wr_en      = wr_active && i_in_vld && !i_sync && !i_slot_sync;
    assign addr_inc   = {1'b0, addr} + {{AW{1'b0}}, 1'b1};
    assign slot_end   = (addr == '1) || (addr_inc >= slot_len);

    // Reader-side next state; a same-cycle sync steers around the half being published.
    always_comb begin
        ready_d   = o_frame_ready;
        rd_half_d = rd_half;
        if (i_complite) begin
            if (frame_free) begin
                ready_d   = 1'b1;
                rd_half_d = wr_half;
            end
        end else if (i_frame_ack) begin
            ready_d = 1'b0;
        end
        nxt_half = ((ready_d ? rd_half_d : wr_half) == HALF0) ? HALF1 : HALF0;
    end

    always_comb begin
        cnt_sum = 16'(NCH);
        for (int v = 0; v < NCH; v++) begin
            cnt_sum = cnt_sum + 16'(cnt[{wr_half, VW'(v)}]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_half   <= HALF0;
            addr      <= '0;
            wr_active <= 1'b0;
            slot_vchn <= '0;
            slot_len  <= '0;
            for (int i = 0; i < 2 * NCH; i++) begin
                cnt[i] <= '0;
            end
        end else if (i_sync) begin
            wr_half   <= nxt_half;
            wr_active <= 1'b0;
            for (int v = 0; v < NCH; v++) begin
                cnt[{nxt_half, VW'(v)}] <= '0;
            end
        end else if (i_slot_sync) begin
            if (wr_active) begin
                cnt[{wr_half, slot_vchn}] <= {1'b0, addr};
            end
            addr      <= '0;
            slot_vchn <= i_wr_vchn;
            wr_active <= (i_data_len != '0);
            slot_len  <= i_data_len;
        end else if (wr_en) begin
            if (slot_end) begin
                wr_active                 <= 1'b0;
                cnt[{wr_half, slot_vchn}] <= addr_inc;
            end else begin
                addr <= addr_inc[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_half       <= HALF0;
            o_frame_ready <= 1'b0;
            o_out_size    <= '0;
            o_drop_cnt    <= '0;
            for (int v = 0; v < NCH; v++) begin
                snap[v] <= '0;
            end
        end else begin
            rd_half       <= rd_half_d;
            o_frame_ready <= ready_d;
            if (publish) begin
                o_out_size <= cnt_sum;
                for (int v = 0; v < NCH; v++) begin
                    snap[v] <= cnt[{wr_half, VW'(v)}];
                end
            end else if (i_complite && (o_drop_cnt != '1)) begin
                o_drop_cnt <= o_drop_cnt + 1'b1;
            end
        end
    end

    // RAM output is not reset, so mask it for the cycle following reset.
    always_ff @(posedge clk) begin
        rd_clr <= rst;
    end

    assign o_rd_data    = rd_clr ? '0 : ram_rdata;
    assign o_data_count = snap[i_rd_vchn];

    pp_frame_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (RAW'({wr_half, slot_vchn, addr})),
        .wdata_i (i_in_data),
        .raddr_i (RAW'({rd_half, i_rd_vchn, i_rd_addr})),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_phy_channel_pp.sv
// Directed bench for phy_channel_pp; read data is checked through an expected-value queue.
module tb_phy_channel_pp;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int DCW = 8;
    localparam int VW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_sync = 1'b0, i_slot_sync = 1'b0, i_in_vld = 1'b0;
    logic           i_complite = 1'b0, i_frame_ack = 1'b0;
    logic [VW-1:0]  i_wr_vchn = '0, i_rd_vchn = '0;
    logic [AW:0]    i_data_len = '0;
    logic [DW-1:0]  i_in_data = '0;
    logic [AW-1:0]  i_rd_addr = '0;
    logic [DW-1:0]  o_rd_data;
    logic [AW:0]    o_data_count;
    logic [15:0]    o_out_size;
    logic           o_frame_ready;
    logic [DCW-1:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          v;
        int          a;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_req = 1'b0;
    logic    rd_vld = 1'b0;

    phy_channel_pp #(
        .NCH (NCH),
        .DW  (DW),
        .AW  (AW),
        .DCW (DCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_sync        (i_sync),
        .i_slot_sync   (i_slot_sync),
        .i_wr_vchn     (i_wr_vchn),
        .i_data_len    (i_data_len),
        .i_in_vld      (i_in_vld),
        .i_in_data     (i_in_data),
        .i_complite    (i_complite),
        .i_frame_ack   (i_frame_ack),
        .i_rd_vchn     (i_rd_vchn),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_data_count  (o_data_count),
        .o_out_size    (o_out_size),
        .o_frame_ready (o_frame_ready),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Read data appears one cycle after the address is taken.
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow act=%h exp=none", o_rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (o_rd_data !== e.data) begin
                    errors++;
                    $display("FAIL rd v%0d a%0d act=%h exp=%h", e.v, e.a, o_rd_data, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync();
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
    endtask

    task automatic do_slot(input int v, input int len);
        i_slot_sync = 1'b1;
        i_wr_vchn   = VW'(v);
        i_data_len  = (AW+1)'(len);
        step();
        i_slot_sync = 1'b0;
    endtask

    task automatic do_sample(input logic [31:0] d);
        i_in_vld  = 1'b1;
        i_in_data = d;
        step();
        i_in_vld  = 1'b0;
    endtask

    task automatic do_complite(input logic ack);
        i_complite  = 1'b1;
        i_frame_ack = ack;
        step();
        i_complite  = 1'b0;
        i_frame_ack = 1'b0;
    endtask

    task automatic do_ack();
        i_frame_ack = 1'b1;
        step();
        i_frame_ack = 1'b0;
    endtask

    task automatic do_rd(input int v, input int a, input logic [31:0] exp);
        rd_exp_t e;
        e.data = exp;
        e.v = v;
        e.a = a;
        exp_q.push_back(e);
        i_rd_vchn = VW'(v);
        i_rd_addr = AW'(a);
        rd_req    = 1'b1;
        step();
        rd_req    = 1'b0;
    endtask

    task automatic chk_cnt(input string name, input int v, input int exp);
        i_rd_vchn = VW'(v);
        #1;
        check(name, 32'(o_data_count), 32'(exp));
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", 32'(o_frame_ready), 0);
        check("rst_size", 32'(o_out_size), 0);
        check("rst_drop", 32'(o_drop_cnt), 0);
        check("rst_rdata", o_rd_data, 0);
        chk_cnt("rst_count", 0, 0);
        rst = 1'b0;
        step();

        // Basic slot: len 5, 8 samples offered
        do_sync();
        do_slot(2, 5);
        for (int i = 0; i < 8; i++) do_sample(32'hA0 + 32'(i));
        do_complite(1'b0);
        check("s1_ready", 32'(o_frame_ready), 1);
        check("s1_size", 32'(o_out_size), 9);
        chk_cnt("s1_cnt2", 2, 5);
        chk_cnt("s1_cnt0", 0, 0);
        chk_cnt("s1_cnt3", 3, 0);
        for (int a = 0; a < 5; a++) do_rd(2, a, 32'hA0 + 32'(a));
        do_ack();
        check("s1_acked", 32'(o_frame_ready), 0);

        // Zero-length slot and an over-long slot clipped at 2^AW words
        do_sync();
        do_slot(1, 0);
        for (int i = 0; i < 10; i++) do_sample(32'h77);
        do_slot(0, 300);
        for (int i = 0; i < 256; i++) do_sample(32'h1000 + 32'(i));
        for (int i = 0; i < 3; i++) do_sample(32'hDEAD);
        do_complite(1'b0);
        check("s2_size", 32'(o_out_size), 260);
        chk_cnt("s2_cnt0", 0, 256);
        chk_cnt("s2_cnt1", 1, 0);
        do_rd(0, 0, 32'h1000);
        do_rd(0, 128, 32'h1080);
        do_rd(0, 255, 32'h10FF);
        do_ack();

        // Partial commit on a new slot sync
        do_sync();
        do_slot(3, 20);
        for (int i = 0; i < 7; i++) do_sample(32'h30 + 32'(i));
        do_slot(1, 3);
        for (int i = 0; i < 3; i++) do_sample(32'h40 + 32'(i));
        do_complite(1'b0);
        check("s3_size", 32'(o_out_size), 14);
        chk_cnt("s3_cnt3", 3, 7);
        chk_cnt("s3_cnt1", 1, 3);
        do_rd(3, 0, 32'h30);
        do_rd(3, 6, 32'h36);
        do_rd(1, 2, 32'h42);

        // Frame held: two more frames are dropped, held data stays readable
        do_sync();
        do_slot(0, 2);
        do_sample(32'hB0);
        do_sample(32'hB1);
        do_complite(1'b0);
        do_sync();
        do_slot(0, 2);
        do_sample(32'hC0);
        do_sample(32'hC1);
        do_complite(1'b0);
        check("s4_drop", 32'(o_drop_cnt), 2);
        check("s4_ready", 32'(o_frame_ready), 1);
        check("s4_size_held", 32'(o_out_size), 14);
        do_rd(3, 0, 32'h30);
        do_rd(1, 2, 32'h42);
        do_ack();
        check("s4_acked", 32'(o_frame_ready), 0);
        do_complite(1'b0);
        check("s4_new_size", 32'(o_out_size), 6);
        chk_cnt("s4_new_cnt0", 0, 2);
        do_rd(0, 0, 32'hC0);
        do_rd(0, 1, 32'hC1);

        // Ack and complete in the same cycle while ready
        do_sync();
        do_slot(2, 1);
        do_sample(32'hD0);
        do_complite(1'b1);
        check("s5_ready", 32'(o_frame_ready), 1);
        check("s5_drop", 32'(o_drop_cnt), 2);
        check("s5_size", 32'(o_out_size), 5);
        chk_cnt("s5_cnt2", 2, 1);
        do_rd(2, 0, 32'hD0);

        // Reset in the middle of a slot
        do_slot(0, 10);
        do_sample(32'hE0);
        do_sample(32'hE1);
        do_sample(32'hE2);
        rst = 1'b1;
        step();
        check("s6_ready", 32'(o_frame_ready), 0);
        check("s6_size", 32'(o_out_size), 0);
        check("s6_drop", 32'(o_drop_cnt), 0);
        check("s6_rdata", o_rd_data, 0);
        chk_cnt("s6_cnt2", 2, 0);
        rst = 1'b0;
        step();
        do_slot(1, 2);
        do_sample(32'hF0);
        do_sample(32'hF1);
        do_complite(1'b0);
        check("s6_pub_size", 32'(o_out_size), 6);
        chk_cnt("s6_cnt1", 1, 2);
        do_rd(1, 0, 32'hF0);
        do_rd(1, 1, 32'hF1);

        // Drop counter saturation
        for (int i = 0; i < (1 << DCW) + 3; i++) do_complite(1'b0);
        check("s7_drop_sat", 32'(o_drop_cnt), 32'hFF);
        check("s7_ready", 32'(o_frame_ready), 1);
        check("s7_size", 32'(o_out_size), 6);

        repeat (3) step();
        check("rd_drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
